stopwatch_lap_timer: RTL and testbench

//  Parametrised successor to the start/stop/reset stopwatch: min:sec timekeeper with internal tick

---
 rtl/stopwatch_lap_timer_if.sv | 33 +++
 rtl/stopwatch_lap_timer.sv | 134 +++++++++++++
 tb/tb_stopwatch_lap_timer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_timer_if.sv
// Button/preset inputs and time/lap/status outputs of the stopwatch lap timer.
// master drives the buttons and presets; slave is the timer itself.
interface stopwatch_lap_timer_if #(
  parameter int unsigned MIN_W     = 8,
  parameter int unsigned LAP_CNT_W = 4
);
  logic                 start;
  logic                 stop;
  logic                 reset;
  logic                 lap;
  logic                 mode;
  logic                 load;
  logic [MIN_W-1:0]     load_min;
  logic [5:0]           load_sec;
  logic [MIN_W-1:0]     minutes;
  logic [5:0]           seconds;
  logic [MIN_W-1:0]     lap_min;
  logic [5:0]           lap_sec;
  logic [LAP_CNT_W-1:0] lap_count;
  logic                 lap_valid;
  logic                 expired;
  logic [1:0]           status;

  modport master (
    output start, stop, reset, lap, mode, load, load_min, load_sec,
    input  minutes, seconds, lap_min, lap_sec, lap_count, lap_valid, expired, status
  );

  modport slave (
    input  start, stop, reset, lap, mode, load, load_min, load_sec,
    output minutes, seconds, lap_min, lap_sec, lap_count, lap_valid, expired, status
  );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// min:sec stopwatch with tick prescaler, up/down counting, preset load, lap capture and
// terminal detection. All outputs come straight from registers.
module stopwatch_lap_timer #(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned MIN_W     = 8,
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned LAP_CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  stopwatch_lap_timer_if.slave sw_io
);
  localparam int unsigned      PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PrescLast = PW'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0] MaxMin    = MIN_W'(MAX_MIN);
  localparam logic [5:0]       SecLast   = 6'd59;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        presc_q;
  logic                 mode_q;
  logic [MIN_W-1:0]     min_q, lap_min_q;
  logic [5:0]           sec_q, lap_sec_q;
  logic [LAP_CNT_W-1:0] lap_cnt_q;
  logic                 lap_valid_q, expired_q;

  logic [MIN_W-1:0] step_min, ld_min;
  logic [5:0]       step_sec, ld_sec;
  logic             tick, step_term, start_blocked, lap_ok;

  // Time value one tick later in the latched direction.
  always_comb begin
    step_min = min_q;
    step_sec = sec_q;
    if (mode_q) begin
      if (sec_q == 6'd0) begin
        step_sec = SecLast;
        step_min = min_q - 1'b1;
      end else begin
        step_sec = sec_q - 6'd1;
      end
    end else begin
      if (sec_q == SecLast) begin
        step_sec = 6'd0;
        step_min = min_q + 1'b1;
      end else begin
        step_sec = sec_q + 6'd1;
      end
    end
  end

  assign tick      = (presc_q == PrescLast);
  assign step_term = mode_q ? (step_min == '0 && step_sec == '0)
                            : (step_min == MaxMin && step_sec == SecLast);
  // Starting from the terminal value of the requested direction would expire at once.
  assign start_blocked = sw_io.mode ? (min_q == '0 && sec_q == '0)
                                    : (min_q == MaxMin && sec_q == SecLast);
  assign ld_min = (sw_io.load_min > MaxMin) ? MaxMin : sw_io.load_min;
  assign ld_sec = (sw_io.load_sec > SecLast) ? SecLast : sw_io.load_sec;
  assign lap_ok = sw_io.lap && !sw_io.reset && !sw_io.load &&
                  (state_q == StRun || state_q == StPause);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      min_q       <= '0;
      sec_q       <= '0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_cnt_q   <= '0;
      lap_valid_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      lap_valid_q <= 1'b0;
      expired_q   <= 1'b0;
      if (lap_ok) begin
        lap_min_q   <= min_q;
        lap_sec_q   <= sec_q;
        lap_valid_q <= 1'b1;
        if (lap_cnt_q != '1) lap_cnt_q <= lap_cnt_q + 1'b1;
      end

      if (sw_io.reset) begin
        state_q   <= StIdle;
        presc_q   <= '0;
        min_q     <= '0;
        sec_q     <= '0;
        lap_min_q <= '0;
        lap_sec_q <= '0;
        lap_cnt_q <= '0;
      end else if (sw_io.load && state_q != StRun) begin
        min_q   <= ld_min;
        sec_q   <= ld_sec;
        presc_q <= '0;
        if (state_q == StDone) state_q <= StIdle;
      end else if (sw_io.stop && state_q == StRun) begin
        state_q <= StPause;
      end else if (sw_io.start && (state_q == StIdle || state_q == StPause) &&
                   !start_blocked) begin
        state_q <= StRun;
        mode_q  <= sw_io.mode;
      end else if (state_q == StRun) begin
        if (tick) begin
          presc_q <= '0;
          min_q   <= step_min;
          sec_q   <= step_sec;
          if (step_term) begin
            state_q   <= StDone;
            expired_q <= 1'b1;
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  assign sw_io.minutes   = min_q;
  assign sw_io.seconds   = sec_q;
  assign sw_io.lap_min   = lap_min_q;
  assign sw_io.lap_sec   = lap_sec_q;
  assign sw_io.lap_count = lap_cnt_q;
  assign sw_io.lap_valid = lap_valid_q;
  assign sw_io.expired   = expired_q;
  assign sw_io.status    = state_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: directed scenarios plus random button traffic, all checked
// against a seconds-count reference model; a second instance covers MAX_MIN=99 clamping.
module tb_stopwatch_lap_timer;
  localparam int unsigned TD  = 4;
  localparam int unsigned MW  = 8;
  localparam int unsigned MM  = 2;
  localparam int unsigned LCW = 4;
  localparam int          LAP_SAT = (1 << LCW) - 1;

  logic clk;
  logic rst_n;
  stopwatch_lap_timer_if #(.MIN_W(MW), .LAP_CNT_W(LCW)) sw ();
  stopwatch_lap_timer_if #(.MIN_W(MW), .LAP_CNT_W(LCW)) i99 ();

  stopwatch_lap_timer #(.TICK_DIV(TD), .MIN_W(MW), .MAX_MIN(MM), .LAP_CNT_W(LCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_io (sw)
  );

  stopwatch_lap_timer #(.TICK_DIV(TD), .MIN_W(MW), .MAX_MIN(99), .LAP_CNT_W(LCW)) dut99 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_io (i99)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  bit s_start, s_stop, s_reset, s_lap, s_mode, s_load;
  int s_load_min, s_load_sec;

  // Reference model: time held as total seconds, state as status code
  int m_st, m_t, m_ph, m_lap_t, m_lap_cnt;
  bit m_mode, m_lap_valid, m_exp;

  function automatic int term_of(input bit md);
    return md ? 0 : int'(MM) * 60 + 59;
  endfunction

  task automatic model_clear();
    m_st = 0; m_t = 0; m_ph = 0; m_lap_t = 0; m_lap_cnt = 0;
    m_mode = 0; m_lap_valid = 0; m_exp = 0;
  endtask

  task automatic model_edge();
    int lm, ls;
    m_lap_valid = 0;
    m_exp = 0;
    if (s_lap && !s_reset && !s_load && (m_st == 1 || m_st == 2)) begin
      m_lap_t = m_t;
      m_lap_valid = 1;
      if (m_lap_cnt < LAP_SAT) m_lap_cnt++;
    end
    lm = (s_load_min > int'(MM)) ? int'(MM) : s_load_min;
    ls = (s_load_sec > 59) ? 59 : s_load_sec;
    if (s_reset) begin
      m_st = 0; m_t = 0; m_ph = 0; m_lap_t = 0; m_lap_cnt = 0;
    end else if (s_load && m_st != 1) begin
      m_t = lm * 60 + ls;
      m_ph = 0;
      if (m_st == 3) m_st = 0;
    end else if (s_stop && m_st == 1) begin
      m_st = 2;
    end else if (s_start && (m_st == 0 || m_st == 2) && m_t != term_of(s_mode)) begin
      m_st = 1;
      m_mode = s_mode;
    end else if (m_st == 1) begin
      if (m_ph == int'(TD) - 1) begin
        m_ph = 0;
        m_t = m_mode ? m_t - 1 : m_t + 1;
        if (m_t == term_of(m_mode)) begin
          m_st = 3;
          m_exp = 1;
        end
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("status",    int'(sw.status),    m_st);
    check_eq("minutes",   int'(sw.minutes),   m_t / 60);
    check_eq("seconds",   int'(sw.seconds),   m_t % 60);
    check_eq("lap_min",   int'(sw.lap_min),   m_lap_t / 60);
    check_eq("lap_sec",   int'(sw.lap_sec),   m_lap_t % 60);
    check_eq("lap_count", int'(sw.lap_count), m_lap_cnt);
    check_eq("lap_valid", int'(sw.lap_valid), int'(m_lap_valid));
    check_eq("expired",   int'(sw.expired),   int'(m_exp));
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample just after it.
  task automatic step();
    @(negedge clk);
    sw.start    = s_start;
    sw.stop     = s_stop;
    sw.reset    = s_reset;
    sw.lap      = s_lap;
    sw.mode     = s_mode;
    sw.load     = s_load;
    sw.load_min = MW'(s_load_min);
    sw.load_sec = 6'(s_load_sec);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    s_start = 0; s_stop = 0; s_reset = 0; s_lap = 0; s_load = 0;
  endtask

  task automatic do_load(input int mn, input int sc);
    s_load = 1; s_load_min = mn; s_load_sec = sc;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 0; s_stop = 0; s_reset = 0; s_lap = 0; s_mode = 0; s_load = 0;
    s_load_min = 0; s_load_sec = 0;
    sw.start = 0; sw.stop = 0; sw.reset = 0; sw.lap = 0; sw.mode = 0; sw.load = 0;
    sw.load_min = '0; sw.load_sec = '0;
    i99.start = 0; i99.stop = 0; i99.reset = 0; i99.lap = 0; i99.mode = 0; i99.load = 0;
    i99.load_min = '0; i99.load_sec = '0;
    model_clear();
    #12;
    compare_all();
    #8 rst_n = 1'b1;

    // Count up from 0:00
    s_start = 1; step();
    check_eq("run_status", int'(sw.status), 1);
    repeat (4) step();
    check_eq("first_tick_sec", int'(sw.seconds), 1);
    repeat (236) step();
    check_eq("one_min_min", int'(sw.minutes), 1);
    check_eq("one_min_sec", int'(sw.seconds), 0);

    // Pause keeps time and prescaler phase
    s_reset = 1; step();
    s_start = 1; step();
    repeat (42) step();
    s_stop = 1; step();
    check_eq("pause_status", int'(sw.status), 2);
    repeat (200) step();
    check_eq("pause_hold", int'(sw.seconds), 10);
    s_start = 1; step();
    step();
    check_eq("resume_pre", int'(sw.seconds), 10);
    step();
    check_eq("resume_phase", int'(sw.seconds), 11);

    // Up-count terminal 2:59
    s_reset = 1; step();
    do_load(2, 58);
    s_mode = 0; s_start = 1; step();
    repeat (4) step();
    check_eq("up_done", int'(sw.status), 3);
    check_eq("up_expired", int'(sw.expired), 1);
    check_eq("up_term_min", int'(sw.minutes), 2);
    step();
    check_eq("expired_once", int'(sw.expired), 0);
    s_start = 1; step();
    check_eq("done_start_ign", int'(sw.status), 3);

    // Countdown to 0:00
    do_load(0, 2);
    s_mode = 1; s_start = 1; step();
    repeat (4) step();
    check_eq("down_first", int'(sw.seconds), 1);
    repeat (4) step();
    check_eq("down_done", int'(sw.status), 3);
    check_eq("down_expired", int'(sw.expired), 1);
    repeat (8) step();
    check_eq("no_underflow", int'(sw.seconds) + int'(sw.minutes), 0);

    // Lap on the tick cycle, then saturation
    s_mode = 0; s_reset = 1; step();
    do_load(0, 5);
    s_start = 1; step();
    repeat (3) step();
    s_lap = 1; step();
    check_eq("lap_pretick", int'(sw.lap_sec), 5);
    check_eq("lap_valid_on", int'(sw.lap_valid), 1);
    check_eq("lap_tick_sec", int'(sw.seconds), 6);
    step();
    check_eq("lap_valid_off", int'(sw.lap_valid), 0);
    s_stop = 1; step();
    for (int i = 0; i < 17; i++) begin
      s_lap = 1; step();
    end
    check_eq("lap_saturate", int'(sw.lap_count), LAP_SAT);
    s_reset = 1; step();
    check_eq("lap_cnt_clear", int'(sw.lap_count), 0);

    // Asynchronous reset mid-run
    s_start = 1; step();
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_status", int'(sw.status), 0);
    check_eq("arst_sec", int'(sw.seconds), 0);
    model_clear();
    #5 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s_start    = ($urandom_range(0, 7) == 0);
      s_stop     = ($urandom_range(0, 29) == 0);
      s_reset    = ($urandom_range(0, 399) == 0);
      s_lap      = ($urandom_range(0, 9) == 0);
      s_load     = ($urandom_range(0, 59) == 0);
      s_mode     = 1'($urandom_range(0, 1));
      s_load_min = int'($urandom_range(0, 5));
      s_load_sec = int'($urandom_range(0, 63));
      step();
    end

    // MAX_MIN=99 instance: clamping and load ignored in RUN
    @(negedge clk);
    i99.load = 1; i99.load_min = 8'd150; i99.load_sec = 6'd63;
    @(negedge clk);
    i99.load = 0;
    check_eq("clamp99_min", int'(i99.minutes), 99);
    check_eq("clamp99_sec", int'(i99.seconds), 59);
    i99.start = 1; i99.mode = 0;
    @(negedge clk);
    i99.start = 0;
    check_eq("term_start_ign", int'(i99.status), 0);
    i99.load = 1; i99.load_min = 8'd1; i99.load_sec = 6'd0;
    @(negedge clk);
    i99.load = 0; i99.start = 1;
    @(negedge clk);
    i99.start = 0; i99.load = 1; i99.load_min = 8'd0; i99.load_sec = 6'd30;
    @(negedge clk);
    i99.load = 0;
    check_eq("run_load_ign", int'(i99.minutes), 1);
    check_eq("run_load_state", int'(i99.status), 1);
    i99.reset = 1;
    @(negedge clk);
    i99.reset = 0;
    check_eq("sync_rst_status", int'(i99.status), 0);
    check_eq("sync_rst_min", int'(i99.minutes), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
